// File: rtl/imm_decode_pkg.sv
// Shared constants and types for the immediate decode/handoff stage.
// Holds immsel codes, RV32I opcodes, state encoding and the entry bundle.
package imm_decode_pkg;

    localparam logic [2:0] IMMSEL_I    = 3'b000;
    localparam logic [2:0] IMMSEL_S    = 3'b001;
    localparam logic [2:0] IMMSEL_B    = 3'b010;
    localparam logic [2:0] IMMSEL_J    = 3'b011;
    localparam logic [2:0] IMMSEL_U    = 3'b100;
    localparam logic [2:0] IMMSEL_NONE = 3'b111;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  immsel;
        logic        illegal;
    } entry_t;

    localparam entry_t RST_ENTRY = '{
        instr:   NOP_INSTR,
        pc:      32'h0,
        immsel:  IMMSEL_NONE,
        illegal: 1'b0
    };

endpackage

// File: rtl/imm_decode_ctrl_opc.sv
// Opcode classifier: RV32I opcode -> immediate format select.
// Illegal-opcode flagging only exists when IMM_DECODE_ILLEGAL_EN is defined.
module imm_opc_decode
    import imm_decode_pkg::*;
(
    input  logic [6:0] opc,
    output logic [2:0] immsel,
    output logic       illegal
);

    // Map opcode to the immediate generator's format select.
    always_comb begin
        immsel = IMMSEL_NONE;
        case (opc)
            OPC_LOAD, OPC_OPIMM,
            OPC_JALR, OPC_SYSTEM: immsel = IMMSEL_I;
            OPC_STORE:            immsel = IMMSEL_S;
            OPC_BRANCH:           immsel = IMMSEL_B;
            OPC_JAL:              immsel = IMMSEL_J;
            OPC_LUI, OPC_AUIPC:   immsel = IMMSEL_U;
            default:              immsel = IMMSEL_NONE;
        endcase
    end

`ifdef IMM_DECODE_ILLEGAL_EN
    // Flag anything outside the RV32I base opcode set or not 32-bit encoded.
    always_comb begin
        illegal = 1'b1;
        case (opc)
            OPC_LOAD, OPC_OPIMM, OPC_JALR,
            OPC_SYSTEM, OPC_STORE, OPC_BRANCH,
            OPC_JAL, OPC_LUI, OPC_AUIPC,
            OPC_OP, OPC_FENCE: illegal = 1'b0;
            default:           illegal = 1'b1;
        endcase
        if (opc[1:0] != 2'b11) begin
            illegal = 1'b1;
        end
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: rtl/imm_decode_ctrl.sv
// Registered decode/handoff stage between fetch and execute with a
// 2-entry skid buffer; IMM_DECODE_ILLEGAL_EN enables illegal flagging.
module imm_decode_ctrl
    import imm_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_immsel,
    output logic            out_illegal
);

    logic [2:0] dec_immsel;
    logic       dec_illegal;
    entry_t     in_ent;

    entry_t     main_q, main_d;
    entry_t     skid_q, skid_d;
    logic       out_valid_q, out_valid_d;
    logic       skid_valid_q, skid_valid_d;
    logic       in_ready_q, in_ready_d;
    logic [1:0] state_q, state_d;

    logic       accept;
    logic       consume;

    imm_opc_decode u_dec (
        .opc     (in_instr[6:0]),
        .immsel  (dec_immsel),
        .illegal (dec_illegal)
    );

    assign in_ent = '{
        instr:   in_instr,
        pc:      in_pc,
        immsel:  dec_immsel,
        illegal: dec_illegal
    };

    assign accept  = in_valid & in_ready_q;
    assign consume = out_valid_q & out_ready;

    // Slot bookkeeping: main register feeds execute, skid absorbs one extra.
    always_comb begin
        state_d      = state_q;
        main_d       = main_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            state_d      = EMPTY;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d      = in_ent;
                        out_valid_d = 1'b1;
                        state_d     = BUSY;
                    end
                end
                BUSY: begin
                    if (accept && consume) begin
                        main_d = in_ent;
                    end else if (accept) begin
                        skid_d       = in_ent;
                        skid_valid_d = 1'b1;
                        state_d      = FULL;
                    end else if (consume) begin
                        out_valid_d = 1'b0;
                        state_d     = EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        main_d       = skid_q;
                        skid_valid_d = 1'b0;
                        state_d      = BUSY;
                    end
                end
                default: begin
                    state_d      = EMPTY;
                    out_valid_d  = 1'b0;
                    skid_valid_d = 1'b0;
                end
            endcase
        end
        in_ready_d = ~skid_valid_d;
    end

    // State and data registers; reset drops all held entries at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            main_q       <= RST_ENTRY;
            skid_q       <= RST_ENTRY;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_instr   = main_q.instr;
    assign out_pc      = main_q.pc;
    assign out_immsel  = main_q.immsel;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Self-checking bench for imm_decode_ctrl: directed steps plus random
// traffic against a FIFO-of-entries reference model.
module tb_imm_decode_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  out_immsel;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    logic [63:0] q[$];

    imm_decode_ctrl #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_immsel  (out_immsel),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] ref_immsel(input logic [31:0] ins);
        logic [6:0] o;
        o = ins[6:0];
        if (o == 7'h03 || o == 7'h13 || o == 7'h67 || o == 7'h73) return 3'd0;
        if (o == 7'h23) return 3'd1;
        if (o == 7'h63) return 3'd2;
        if (o == 7'h6F) return 3'd3;
        if (o == 7'h37 || o == 7'h17) return 3'd4;
        return 3'd7;
    endfunction

    function automatic logic ref_illegal(input logic [31:0] ins);
`ifdef IMM_DECODE_ILLEGAL_EN
        logic [6:0] o;
        o = ins[6:0];
        if (ins[1:0] != 2'b11) return 1'b1;
        return !(o inside {7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
                           7'h6F, 7'h37, 7'h17, 7'h33, 7'h0F});
`else
        return ins[0] & 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [31:0] ei;
        logic [31:0] ep;
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        if (q.size() > 0) begin
            ei = q[0][63:32];
            ep = q[0][31:0];
            chk("out_instr", out_instr, ei);
            chk("out_pc", out_pc, ep);
            chk("out_immsel", {29'd0, out_immsel}, {29'd0, ref_immsel(ei)});
            chk("out_illegal", {31'd0, out_illegal}, {31'd0, ref_illegal(ei)});
        end
    endtask

    task automatic cyc(input logic v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic ordy,
                       input logic fl);
        logic acc;
        logic con;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        acc = v && (q.size() < 2);
        con = ordy && (q.size() > 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back({ins, pc});
        end
        #1;
        check_model();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_instr"}, out_instr, 32'h0000_0013);
        chk({tag, "_pc"}, out_pc, 32'd0);
        chk({tag, "_immsel"}, {29'd0, out_immsel}, 32'd7);
        chk({tag, "_illegal"}, {31'd0, out_illegal}, 32'd0);
    endtask

    logic [6:0] opcs [12] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
                              7'h6F, 7'h37, 7'h17, 7'h33, 7'h0F, 7'h7F};

    initial begin
        logic [31:0] r;
        logic [31:0] ins;
        rst = 1'b1;
        in_valid = 1'b0;
        in_instr = 32'd0;
        in_pc = 32'd0;
        flush = 1'b0;
        out_ready = 1'b0;
        #2;
        check_reset_vals("rst0");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Streaming at full rate
        cyc(1, 32'h0050_0093, 32'h100, 1, 0);
        chk("s1_imm0", {29'd0, out_immsel}, 32'd0);
        cyc(1, 32'hFE00_0EE3, 32'h104, 1, 0);
        chk("s1_imm1", {29'd0, out_immsel}, 32'd2);
        cyc(1, 32'h0000_00EF, 32'h108, 1, 0);
        chk("s1_imm2", {29'd0, out_immsel}, 32'd3);
        chk("s1_rdy", {31'd0, in_ready}, 32'd1);
        cyc(0, 32'd0, 32'd0, 1, 0);

        // Back-pressure into the skid slot
        cyc(1, 32'h1234_5037, 32'h200, 0, 0);
        chk("s2_rdy_a", {31'd0, in_ready}, 32'd1);
        cyc(1, 32'h0011_2023, 32'h204, 0, 0);
        chk("s2_rdy_b", {31'd0, in_ready}, 32'd0);
        chk("s2_hold", out_instr, 32'h1234_5037);
        chk("s2_imm", {29'd0, out_immsel}, 32'd4);
        cyc(1, 32'h0000_0013, 32'h208, 0, 0);
        chk("s2_stable", out_instr, 32'h1234_5037);
        cyc(0, 32'd0, 32'd0, 1, 0);
        chk("s2_next", out_instr, 32'h0011_2023);
        chk("s2_imm2", {29'd0, out_immsel}, 32'd1);
        cyc(0, 32'd0, 32'd0, 1, 0);
        chk("s2_empty", {31'd0, out_valid}, 32'd0);

        // Flush while full, with an offered input
        cyc(1, 32'h0000_1117, 32'h300, 0, 0);
        cyc(1, 32'h0000_2217, 32'h304, 0, 0);
        cyc(1, 32'hDEAD_B0B7, 32'h308, 0, 1);
        chk("s3_valid", {31'd0, out_valid}, 32'd0);
        chk("s3_rdy", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 32'd0, 32'd0, 1, 0);
            chk("s3_nokill", {31'd0, out_valid}, 32'd0);
        end

        // Asynchronous reset between edges
        cyc(1, 32'h0000_0563, 32'h400, 0, 0);
        cyc(1, 32'h0000_0667, 32'h404, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("s4");
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // R-type and illegal patterns
        cyc(1, 32'h0020_81B3, 32'h500, 1, 0);
        chk("s5_rtype", {29'd0, out_immsel}, 32'd7);
        chk("s5_rill", {31'd0, out_illegal}, 32'd0);
        cyc(1, 32'h0000_007F, 32'h504, 1, 0);
`ifdef IMM_DECODE_ILLEGAL_EN
        chk("s5_ill7f", {31'd0, out_illegal}, 32'd1);
`else
        chk("s5_ill7f", {31'd0, out_illegal}, 32'd0);
`endif
        cyc(1, 32'h0000_0000, 32'h508, 1, 0);
`ifdef IMM_DECODE_ILLEGAL_EN
        chk("s5_ill00", {31'd0, out_illegal}, 32'd1);
`else
        chk("s5_ill00", {31'd0, out_illegal}, 32'd0);
`endif
        chk("s5_imm00", {29'd0, out_immsel}, 32'd7);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            if (r[3:0] == 4'd0)
                ins = $urandom();
            else
                ins = {r[31:7], opcs[$urandom_range(0, 11)]};
            cyc(1'($urandom_range(0, 3) != 0), ins, $urandom(),
                1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 19) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_decode_ctrl.md
Name: imm_decode_ctrl

Overview:
- Registered decode/handoff stage between fetch and execute.
- Classifies each 32-bit RV32I instruction by opcode and produces the 3-bit immediate-format select for the immediate generator. The select is registered alongside the instruction and PC.
- Uses a valid/ready handshake with a 2-entry skid buffer, so full throughput is kept under execute back-pressure.
- Supports a synchronous pipeline flush for branch and jump redirects.

Parameters:
- XLEN, 32, width of the instruction and PC paths; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- flush  in  1  synchronous kill of all held entries
- out_valid  out  1  decoded entry available to execute
- out_ready  in  1  execute accepts
- out_instr  out  32  held instruction, drives the immediate generator instruction input
- out_pc  out  32  held PC
- out_immsel  out  3  format select, drives the immediate generator immsel input
- out_illegal  out  1  unknown opcode (see Optional Feature)

Behaviour:
- Reset (async, active-high) clears:
  - in_ready=1, out_valid=0
  - out_instr=0x00000013 (NOP), out_pc=0, out_immsel=3'b111, out_illegal=0
  - skid_valid=0, state=EMPTY
- Opcode to immsel mapping on instr[6:0]:
  - 0000011, 0010011, 1100111, 1110011 -> 000 (I)
  - 0100011 -> 001 (S)
  - 1100011 -> 010 (B)
  - 1101111 -> 011 (J)
  - 0110111, 0010111 -> 100 (U)
  - 0110011 and all others -> 111 (no immediate; the generator outputs 0)
- Decode is computed on the input side and registered with the entry. Latency from input handshake to out_valid is 1 cycle.
- Handshakes:
  - Input is accepted when in_valid & in_ready.
  - Output is consumed when out_valid & out_ready.
  - Output data stays stable while out_valid & !out_ready.
- States (S = slot count):
  - EMPTY (S=0): accept -> BUSY, loading the main register.
  - BUSY (S=1):
    - accept & consume -> BUSY, main reloaded.
    - accept & !consume -> FULL, incoming entry goes to skid; in_ready drops next cycle.
    - consume only -> EMPTY.
  - FULL (S=2): no accept possible. consume -> BUSY, skid moves to main the same edge and skid_valid clears.
- Ordering is strict FIFO; the skid entry never overtakes the main entry.
- flush:
  - Next state is EMPTY; out_valid=0, skid_valid=0, in_ready=1.
  - Any input accepted in the flush cycle is discarded.
  - Flush takes priority over accept and consume.
- Reset asserted mid-operation drops all entries immediately (asynchronous).
- No combinational path from out_ready to in_ready.

Optional Feature:
- Macro: IMM_DECODE_ILLEGAL_EN.
- Enabled:
  - An opcode outside {0000011, 0010011, 1100111, 1110011, 0100011, 1100011, 1101111, 0110111, 0010111, 0110011, 0001111} sets out_illegal=1 for that entry.
  - instr[1:0]!=2'b11 also flags illegal.
  - Illegal entries still flow through with immsel=111.
- Disabled: out_illegal is tied to 0 and the checking logic is absent.

Decomposition:
- Shared package imm_decode_pkg holds:
  - immsel localparams: IMMSEL_I=000, S=001, B=010, J=011, U=100, NONE=111.
  - Opcode constants OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_LUI, OPC_AUIPC, OPC_OP, OPC_FENCE.
  - State encoding EMPTY/BUSY/FULL.
- One natural combinational sub-module: imm_opc_decode (instr in -> immsel, illegal out). It is instantiated once on the input side.

Test Plan:
1. Back-to-back streaming with out_ready=1: in_instr 0x00500093 then 0xFE000EE3 then 0x000000EF.
   - out_immsel must be 000, 010, 011 on consecutive cycles, each 1 cycle after accept.
   - in_ready must stay 1 throughout.
2. Back-pressure with out_ready=0: send 0x12345037 then 0x00112023.
   - State goes BUSY -> FULL; in_ready goes 0 on the cycle after the second accept.
   - out_instr must hold 0x12345037, immsel 100.
   - Release out_ready: 0x00112023 appears next with immsel 001, then EMPTY.
3. Flush in FULL with in_valid=1.
   - Next cycle: out_valid=0, in_ready=1.
   - The flush-cycle input must never appear at the output.
4. Reset asserted asynchronously mid-stream, between clock edges.
   - Outputs immediately go to their reset values: out_valid=0, out_instr=0x00000013, out_immsel=111.
5. R-type 0x002081B3 -> immsel 111.
   - With IMM_DECODE_ILLEGAL_EN: 0x0000007F gives out_illegal=1, and 0x00000000 gives out_illegal=1.
   - Without the macro: out_illegal stays 0 for all inputs.
